// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline-stage register.
// Widths mirror the core's ctrl/payload bundle layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } pipe_occ_e;

  localparam int XLEN       = 32;
  localparam int REG_W      = 5;
  localparam int PRED_W     = 17;
  localparam int EX_CTRL_W  = 8;
  localparam int MEM_CTRL_W = 4;
  localparam int WB_CTRL_W  = 4;

  localparam int DEF_CTRL_W = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
  localparam int DEF_DATA_W = 4 * XLEN + 3 * REG_W + PRED_W;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer entry: valid flag, control and payload with load/clear.
// Load wins over clear so a slot can be emptied and refilled in one edge.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      // payload kept by default to avoid needless toggling
      if (CLEAR_DATA != 0)
        data <= '0;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic two-entry pipeline stage with hold, flush and stall counter.
// in_ready is a function of registers, hold and flush only.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_occ_e occ, occ_n;

  logic              main_v;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              main_ld;
  logic              main_clr;
  logic              from_skid;
  logic              skid_ld;
  logic              skid_clr;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  logic act;
  logic accept;
  logic fire;

  assign act       = !hold && !flush;
  assign in_ready  = !skid_v && act;
  assign out_valid = main_v && act;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign occupancy = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occ <= OCC_EMPTY;
    else
      occ <= occ_n;
  end

  always_comb begin
    occ_n     = occ;
    main_ld   = 1'b0;
    main_clr  = 1'b0;
    from_skid = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = 1'b0;
    if (!hold && flush) begin
      occ_n    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!hold) begin
      unique case (occ)
        OCC_EMPTY: begin
          if (accept) begin
            occ_n   = OCC_ONE;
            main_ld = 1'b1;
          end
        end
        OCC_ONE: begin
          unique case (1'b1)
            accept && fire: begin
              main_ld = 1'b1;
            end
            accept && !fire: begin
              occ_n   = OCC_FULL;
              skid_ld = 1'b1;
            end
            !accept && fire: begin
              occ_n    = OCC_EMPTY;
              main_clr = 1'b1;
            end
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (fire) begin
            occ_n     = OCC_ONE;
            main_ld   = 1'b1;
            from_skid = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          occ_n    = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_d = from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = from_skid ? skid_data : in_data;

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk(clk),
    .rst_n(rst_n),
    .load(main_ld),
    .clear(main_clr),
    .ctrl_d(main_ctrl_d),
    .data_d(main_data_d),
    .valid(main_v),
    .ctrl(out_ctrl),
    .data(out_data)
  );

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .load(skid_ld),
    .clear(skid_clr),
    .ctrl_d(in_ctrl),
    .data_d(in_data),
    .valid(skid_v),
    .ctrl(skid_ctrl),
    .data(skid_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: handshake, skid, flush, hold, stall count.
// Small widths, CLEAR_DATA=1 and CNT_W=4 so every case fits one instance.
module tb_pipe_skid_stage;

  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hold;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .CTRL_W(CW),
    .DATA_W(DW),
    .CLEAR_DATA(1),
    .CNT_W(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hold(hold),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {8'hA0, c};
  endtask

  task automatic test_reset();
    beat(8'h55);
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin
      nerr++;
      $display("FAIL reset_out got v=%b c=%h occ=%0d want 0/00/0", out_valid, out_ctrl, occupancy);
    end
    nvec++;
    if (stall_cnt !== 4'd0 || out_data !== 16'h0) begin
      nerr++;
      $display("FAIL reset_cnt got cnt=%0d data=%h want 0/0000", stall_cnt, out_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    nvec++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
      nerr++;
      $display("FAIL reset_rel got rdy=%b occ=%0d cnt=%0d want 1/0/0", in_ready, occupancy, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    beat(8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (out_ctrl !== 8'(i) || out_data !== {8'hA0, 8'(i)} || out_valid !== 1'b1 || occupancy !== 2'd1) begin
        nerr++;
        $display("FAIL stream_%0d got c=%h d=%h v=%b occ=%0d want %h/a0%h/1/1",
                 i, out_ctrl, out_data, out_valid, occupancy, 8'(i), 8'(i));
      end
      if (i < 7)
        beat(8'(i + 1));
      else
        in_valid = 1'b0;
    end
    tick();
    nvec++;
    if (occupancy !== 2'd0 || out_ctrl !== 8'h00 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stream_drain got occ=%0d c=%h v=%b want 0/00/0", occupancy, out_ctrl, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    beat(8'd0);
    tick();
    out_ready = 1'b0;
    beat(8'd1);
    tick();
    nvec++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 8'd0) begin
      nerr++;
      $display("FAIL bp_full got occ=%0d rdy=%b c=%h want 2/0/00", occupancy, in_ready, out_ctrl);
    end
    beat(8'd2);
    tick();
    tick();
    nvec++;
    if (stall_cnt !== 4'd2) begin
      nerr++;
      $display("FAIL bp_stall got %0d want 2", stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_ctrl !== 8'd1 || occupancy !== 2'd1 || stall_cnt !== 4'd3) begin
      nerr++;
      $display("FAIL bp_rel1 got c=%h occ=%0d cnt=%0d want 01/1/3", out_ctrl, occupancy, stall_cnt);
    end
    tick();
    nvec++;
    if (out_ctrl !== 8'd2 || occupancy !== 2'd1) begin
      nerr++;
      $display("FAIL bp_rel2 got c=%h occ=%0d want 02/1", out_ctrl, occupancy);
    end
    in_valid = 1'b0;
    tick();
    nvec++;
    if (occupancy !== 2'd0 || out_ctrl !== 8'd0) begin
      nerr++;
      $display("FAIL bp_drain got occ=%0d c=%h want 0/00", occupancy, out_ctrl);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    beat(8'h10);
    tick();
    beat(8'h11);
    tick();
    flush = 1'b1;
    beat(8'h12);
    #1;
    nvec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd2) begin
      nerr++;
      $display("FAIL flush_pre got rdy=%b v=%b occ=%0d want 0/0/2", in_ready, out_valid, occupancy);
    end
    tick();
    nvec++;
    if (occupancy !== 2'd0 || out_ctrl !== 8'd0 || out_data !== 16'h0) begin
      nerr++;
      $display("FAIL flush_post got occ=%0d c=%h d=%h want 0/00/0000", occupancy, out_ctrl, out_data);
    end
    nvec++;
    if (stall_cnt !== 4'd4) begin
      nerr++;
      $display("FAIL flush_stall got %0d want 4", stall_cnt);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    nvec++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_nobeat got occ=%0d v=%b want 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b1;
    beat(8'h20);
    tick();
    hold  = 1'b1;
    flush = 1'b1;
    beat(8'h21);
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (occupancy !== 2'd1 || out_ctrl !== 8'h20 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL hold_%0d got occ=%0d c=%h v=%b rdy=%b want 1/20/0/0",
                 i, occupancy, out_ctrl, out_valid, in_ready);
      end
    end
    hold = 1'b0;
    tick();
    nvec++;
    if (occupancy !== 2'd0 || out_ctrl !== 8'h00 || stall_cnt !== 4'd8) begin
      nerr++;
      $display("FAIL hold_flush got occ=%0d c=%h cnt=%0d want 0/00/8", occupancy, out_ctrl, stall_cnt);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    beat(8'h30);
    tick();
    tick();
    for (int i = 0; i < 14; i++)
      tick();
    nvec++;
    if (stall_cnt !== 4'd14) begin
      nerr++;
      $display("FAIL sat_14 got %0d want 14", stall_cnt);
    end
    for (int i = 0; i < 6; i++)
      tick();
    nvec++;
    if (stall_cnt !== 4'd15 || occupancy !== 2'd2) begin
      nerr++;
      $display("FAIL sat_15 got cnt=%0d occ=%0d want 15/2", stall_cnt, occupancy);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_hold();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
